// File: rtl/maze_bram_arbiter_pkg.sv
// Shared constants and arbiter state encodings for the maze-map BRAM read path.
package maze_pkg;

   localparam int unsigned MAP_ADDR_W    = 8;
   localparam int unsigned MAP_DATA_W    = 9;
   localparam int unsigned CELL_WALL_BIT = 0;
   localparam int unsigned MAP_COLS      = 16;

   // 3-bit encoding leaves spare codes that the FSM steers back to idle
   typedef enum logic [2:0] {
      ARB_IDLE = 3'd0,
      ARB_WAIT = 3'd1,
      ARB_CAPT = 3'd2,
      ARB_RESP = 3'd3
   } arb_state_e;

endpackage

// File: rtl/maze_bram_arbiter_rr_arbiter.sv
// Combinational round-robin winner select: search starts just after the last winner.
module rr_arbiter #(
   parameter  int unsigned N_REQ = 4,
   localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic [N_REQ-1:0] win_onehot_c,
   output logic [IDX_W-1:0] win_idx_c,
   output logic             any_req_c
);

   logic [IDX_W-1:0] idx;
   logic             found;

   // explicit wrap so non-power-of-2 N_REQ never indexes past the last requester
   always_comb begin
      idx       = rr_ptr;
      found     = 1'b0;
      win_idx_c = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx = (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + IDX_W'(1);
         if (!found && req[idx]) begin
            found     = 1'b1;
            win_idx_c = idx;
         end
      end
      any_req_c    = found;
      win_onehot_c = found ? (N_REQ'(1) << win_idx_c) : '0;
   end

endmodule

// File: rtl/maze_bram_arbiter.sv
// Round-robin arbiter sharing the maze-map BRAM read port; one read in flight at a time.
module maze_bram_arbiter
   import maze_pkg::*;
#(
   parameter int unsigned N_REQ    = 4,
   parameter int unsigned ADDR_W   = MAP_ADDR_W,
   parameter int unsigned DATA_W   = MAP_DATA_W,
   parameter int unsigned READ_LAT = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0]       bram_dout,
   output logic [ADDR_W-1:0]       bram_addr,
   output logic                    bram_en,
   output logic [N_REQ-1:0]        gnt,
   output logic [N_REQ-1:0]        rd_valid,
   output logic [DATA_W-1:0]       rd_data,
   output logic                    busy
);

   localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned LAT_W = $clog2(READ_LAT + 1);

   arb_state_e        state, state_nxt;
   logic [PTR_W-1:0]  rr_ptr, rr_ptr_nxt;
   logic [LAT_W-1:0]  lat_cnt, lat_cnt_nxt;
   logic [ADDR_W-1:0] bram_addr_nxt, sel_addr_c;
   logic              bram_en_nxt, busy_nxt;
   logic [N_REQ-1:0]  gnt_nxt, rd_valid_nxt;
   logic [DATA_W-1:0] rd_data_nxt;

   logic [N_REQ-1:0]  win_onehot_c;
   logic [PTR_W-1:0]  win_idx_c;
   logic              any_req_c;

   rr_arbiter #(.N_REQ(N_REQ)) u_rr (
      .req          (req),
      .rr_ptr       (rr_ptr),
      .win_onehot_c (win_onehot_c),
      .win_idx_c    (win_idx_c),
      .any_req_c    (any_req_c)
   );

   // address mux with constant slice bases
   always_comb begin
      sel_addr_c = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (win_idx_c == PTR_W'(i)) sel_addr_c = req_addr[i*ADDR_W +: ADDR_W];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ARB_IDLE;
         rr_ptr    <= PTR_W'(N_REQ - 1);
         lat_cnt   <= '0;
         bram_addr <= '0;
         bram_en   <= 1'b0;
         gnt       <= '0;
         rd_valid  <= '0;
         rd_data   <= '0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         rr_ptr    <= rr_ptr_nxt;
         lat_cnt   <= lat_cnt_nxt;
         bram_addr <= bram_addr_nxt;
         bram_en   <= bram_en_nxt;
         gnt       <= gnt_nxt;
         rd_valid  <= rd_valid_nxt;
         rd_data   <= rd_data_nxt;
         busy      <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      rr_ptr_nxt    = rr_ptr;
      lat_cnt_nxt   = lat_cnt;
      bram_addr_nxt = bram_addr;
      bram_en_nxt   = 1'b0;
      gnt_nxt       = '0;
      rd_valid_nxt  = '0;
      rd_data_nxt   = rd_data;
      case (state)
         ARB_IDLE: begin
            if (any_req_c) begin
               bram_addr_nxt = sel_addr_c;
               bram_en_nxt   = 1'b1;
               gnt_nxt       = win_onehot_c;
               rr_ptr_nxt    = win_idx_c;
               lat_cnt_nxt   = '0;
               state_nxt     = ARB_WAIT;
            end
         end
         ARB_WAIT: begin
            lat_cnt_nxt = lat_cnt + LAT_W'(1);
            if (lat_cnt == LAT_W'(READ_LAT - 1)) state_nxt = ARB_CAPT;
         end
         ARB_CAPT: begin
            rd_data_nxt  = bram_dout;
            rd_valid_nxt = N_REQ'(1) << rr_ptr;
            state_nxt    = ARB_RESP;
         end
         ARB_RESP: state_nxt = ARB_IDLE;
         default:  state_nxt = ARB_IDLE;
      endcase
      busy_nxt = (state_nxt != ARB_IDLE);
   end

endmodule

// File: tb/tb_maze_bram_arbiter.sv
// Randomized and directed bench for two arbiter instances (read latency 1 and 3) against a timeline model.
module tb_maze_bram_arbiter;

   logic             clk = 1'b0;
   logic             reset;
   logic [3:0]       req;
   logic [31:0]      req_addr;
   logic [1:0][8:0]  dout;
   logic [1:0][7:0]  o_baddr;
   logic [1:0]       o_en, o_busy;
   logic [1:0][3:0]  o_gnt, o_rv;
   logic [1:0][8:0]  o_data;

   logic [8:0] mem [256];
   logic [8:0] p1;
   logic [8:0] p3 [3];

   int n_tests = 0;
   int n_fail  = 0;

   // model: ph = cycles since grant edge (0 = idle), ptr = last winner
   int         ph    [2] = '{0, 0};
   int         ptr   [2] = '{3, 3};
   int         win   [2] = '{0, 0};
   logic [7:0] eaddr [2] = '{8'h0, 8'h0};
   logic [8:0] edata [2] = '{9'h0, 9'h0};

   always #5 clk = ~clk;

   maze_bram_arbiter #(.N_REQ(4), .ADDR_W(8), .DATA_W(9), .READ_LAT(1)) dut1 (
      .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .bram_dout(dout[0]),
      .bram_addr(o_baddr[0]), .bram_en(o_en[0]), .gnt(o_gnt[0]), .rd_valid(o_rv[0]),
      .rd_data(o_data[0]), .busy(o_busy[0]));

   maze_bram_arbiter #(.N_REQ(4), .ADDR_W(8), .DATA_W(9), .READ_LAT(3)) dut3 (
      .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .bram_dout(dout[1]),
      .bram_addr(o_baddr[1]), .bram_en(o_en[1]), .gnt(o_gnt[1]), .rd_valid(o_rv[1]),
      .rd_data(o_data[1]), .busy(o_busy[1]));

   // BRAM models: READ_LAT register stages after the registered address
   always @(posedge clk) begin
      p1    <= mem[o_baddr[0]];
      p3[0] <= mem[o_baddr[1]];
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign dout[0] = p1;
   assign dout[1] = p3[2];

   function automatic int lat_of(int k);
      return (k == 0) ? 1 : 3;
   endfunction

   function automatic int pick(logic [3:0] r, int p);
      for (int j = 1; j <= 4; j++) begin
         int c;
         c = (p + j) % 4;
         if (r[c]) return c;
      end
      return -1;
   endfunction

   function automatic int oh2i(logic [3:0] v);
      for (int j = 0; j < 4; j++) if (v == (4'b0001 << j)) return j;
      return -1;
   endfunction

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // inputs are unchanged since the last negedge, so they are what the last posedge saw
   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            ph[k] = 0; ptr[k] = 3; eaddr[k] = '0; edata[k] = '0;
         end else if (ph[k] == 0) begin
            if (req != 4'b0) begin
               win[k]   = pick(req, ptr[k]);
               ptr[k]   = win[k];
               eaddr[k] = req_addr[win[k]*8 +: 8];
               ph[k]    = 1;
            end
         end else begin
            ph[k] = (ph[k] == lat_of(k) + 2) ? 0 : ph[k] + 1;
            if (ph[k] == lat_of(k) + 2) edata[k] = mem[eaddr[k]];
         end
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         int         l;
         logic [3:0] oh;
         l  = lat_of(k);
         oh = 4'b0001 << win[k];
         check($sformatf("busy_L%0d", l),  32'(o_busy[k]), 32'(ph[k] != 0));
         check($sformatf("en_L%0d", l),    32'(o_en[k]),   32'(ph[k] == 1));
         check($sformatf("gnt_L%0d", l),   32'(o_gnt[k]),  (ph[k] == 1) ? 32'(oh) : 32'h0);
         check($sformatf("rdv_L%0d", l),   32'(o_rv[k]),   (ph[k] == l + 2) ? 32'(oh) : 32'h0);
         check($sformatf("addr_L%0d", l),  32'(o_baddr[k]), 32'(eaddr[k]));
         check($sformatf("data_L%0d", l),  32'(o_data[k]), 32'(edata[k]));
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      model_step();
      check_all();
   endtask

   task automatic do_reset();
      reset = 1'b1; req = '0;
      cyc(); cyc();
      reset = 1'b0;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      int order [5];
      int exp5  [5];
      int n, g, hits;

      for (int i = 0; i < 256; i++) mem[i] = 9'($urandom);
      mem[8'h35] = 9'h000;
      reset = 1'b1; req = '0; req_addr = 32'h13_22_41_80;
      do_reset();
      check("rst_busy", 32'(o_busy), 32'h0);
      check("rst_gnt",  32'(o_gnt),  32'h0);

      // single request from requester 2
      req = 4'b0100; req_addr[16 +: 8] = 8'h35;
      cyc();
      check("t1_gnt", 32'(o_gnt[0]), 32'h4);
      check("t1_addr", 32'(o_baddr[0]), 32'h35);
      req = '0;
      cyc(); cyc();
      check("t1_rdv", 32'(o_rv[0]), 32'h4);
      check("t1_data", 32'(o_data[0]), 32'h0);
      cyc(); cyc();
      check("t5_rdv_lat3", 32'(o_rv[1]), 32'h4);
      check("t5_data_lat3", 32'(o_data[1]), 32'h0);
      idle(4);

      // all four held: order 0,1,2,3,0 from reset
      do_reset();
      req_addr = 32'h80_41_22_13; req = 4'b1111;
      exp5 = '{0, 1, 2, 3, 0};
      order = '{-1, -1, -1, -1, -1};
      n = 0;
      for (int c = 0; c < 40 && n < 5; c++) begin
         cyc();
         g = oh2i(o_gnt[0]);
         if (g >= 0) begin order[n] = g; n++; end
      end
      for (int i = 0; i < 5; i++) check($sformatf("t2_order%0d", i), 32'(order[i]), 32'(exp5[i]));
      req = '0; idle(8);

      // requester 1 raised during requester 3's read is served next
      do_reset();
      req = 4'b1000;
      g = -1;
      for (int c = 0; c < 10 && g < 0; c++) begin cyc(); g = oh2i(o_gnt[0]); end
      check("t3_first", 32'(g), 32'd3);
      req[1] = 1'b1;
      order = '{-1, -1, -1, -1, -1};
      n = 0;
      for (int c = 0; c < 40 && n < 2; c++) begin
         cyc();
         g = oh2i(o_gnt[0]);
         if (g >= 0) begin order[n] = g; n++; if (g == 1) req[1] = 1'b0; end
      end
      check("t3_next", 32'(order[0]), 32'd1);
      check("t3_then", 32'(order[1]), 32'd3);
      req = '0; idle(8);

      // reset while waiting on the BRAM aborts the read
      do_reset();
      req = 4'b0001;
      cyc();
      req = '0; reset = 1'b1;
      cyc();
      check("t4_busy", 32'(o_busy), 32'h0);
      check("t4_rdv", 32'({o_rv[1], o_rv[0]}), 32'h0);
      reset = 1'b0; req = 4'b1111;
      g = -1;
      for (int c = 0; c < 10 && g < 0; c++) begin cyc(); g = oh2i(o_gnt[0]); end
      check("t4_next", 32'(g), 32'd0);
      req = '0; idle(10);

      // one-cycle pulse while busy is never granted
      req = 4'b0100;
      cyc();
      req = 4'b0010;
      cyc();
      req = '0;
      hits = 0;
      for (int c = 0; c < 12; c++) begin
         cyc();
         if (o_gnt[0][1] || o_gnt[1][1]) hits++;
      end
      check("t6_hits", 32'(hits), 32'd0);
      check("t6_idle", 32'(o_busy), 32'h0);

      // random traffic with occasional reset
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 4; i++) begin
            if (req[i]) begin
               if ($urandom_range(0, 3) == 0) req[i] = 1'b0;
            end else if ($urandom_range(0, 4) == 0) begin
               req[i] = 1'b1;
               req_addr[i*8 +: 8] = 8'($urandom);
            end
         end
         reset = ($urandom_range(0, 199) == 0);
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
